// File: rtl/onehot_serial_encoder.sv
// Serialises a request vector into binary indices, lowest set bit first.
// Define ONEHOT_ENC_LAST_EN to add the out_last port.
module onehot_serial_encoder #(
    parameter  int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_bits,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W:0]   pend_cnt
`ifdef ONEHOT_ENC_LAST_EN
    ,
    output logic             out_last
`endif
);

    typedef enum logic {IDLE, SERVE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pend_q, pend_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W:0]     cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               upd;

    function automatic logic [IDX_W-1:0] lowest(input logic [WIDTH-1:0] p);
        logic [IDX_W-1:0] r;
        r = '0;
        // Scan downwards so the last hit is the lowest set bit
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (p[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic [IDX_W:0] popcnt(input logic [WIDTH-1:0] p);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + (IDX_W + 1)'(p[i]);
        end
        return c;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        upd     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_bits != '0) begin
                    pend_d  = in_bits;
                    state_d = SERVE;
                    upd     = 1'b1;
                end
            end
            SERVE: begin
                if (out_ready) begin
                    pend_d = pend_q & ~(WIDTH'(1) << idx_q);
                    if (pend_d == '0) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        upd = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Index and count come from the next-pending value so both are flops
        if (upd) begin
            idx_d = lowest(pend_d);
            cnt_d = popcnt(pend_d);
        end
        last_d = (cnt_d == (IDX_W + 1)'(1));
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == SERVE);
    assign out_idx   = idx_q;
    assign pend_cnt  = cnt_q;
`ifdef ONEHOT_ENC_LAST_EN
    assign out_last  = last_q;
`else
    logic unused_last;
    assign unused_last = last_q;
`endif

endmodule

// File: tb/tb_onehot_serial_encoder.sv
// Scoreboard bench for onehot_serial_encoder with directed vectors.
// A negedge monitor pops expected indices on every handshake.
module tb_onehot_serial_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_bits = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] out_idx;
    logic [3:0] pend_cnt;
    logic       out_last;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int idx;
        int cnt;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    onehot_serial_encoder #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_bits  (in_bits),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_idx  (out_idx),
        .pend_cnt (pend_cnt)
`ifdef ONEHOT_ENC_LAST_EN
        ,
        .out_last (out_last)
`endif
    );

`ifndef ONEHOT_ENC_LAST_EN
    assign out_last = 1'b0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int idx, input int cnt);
        exp_t e;
        e.idx = idx;
        e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic cycle(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [7:0] v);
        int budget;
        budget = 0;
        while (!in_ready && budget < 50) begin
            cycle();
            budget++;
        end
        if (!in_ready) chk("load_wait_in_ready", 0, 1);
        in_valid = 1'b1;
        in_bits  = v;
        cycle();
        in_valid = 1'b0;
        in_bits  = '0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_index", int'(out_idx), -1);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_idx", int'(out_idx), e.idx);
                chk("pend_cnt", int'(pend_cnt), e.cnt);
`ifdef ONEHOT_ENC_LAST_EN
                chk("out_last", int'(out_last), int'(e.cnt == 1));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Asynchronous reset, checked before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_pend_cnt", int'(pend_cnt), 0);
        chk("rst_out_last", int'(out_last), 0);
        cycle(2);
        rst = 1'b0;
        cycle();

        // Single bit
        out_ready = 1'b1;
        push(5, 1);
        load(8'b0010_0000);
        chk("single_valid", int'(out_valid), 1);
        chk("single_busy", int'(in_ready), 0);
        cycle();
        chk("single_done_valid", int'(out_valid), 0);
        chk("single_done_ready", int'(in_ready), 1);

        // Full vector, one index per cycle
        for (int i = 0; i < 8; i++) push(i, 8 - i);
        load(8'hFF);
        cycle(7);
        chk("full_last_valid", int'(out_valid), 1);
        chk("full_q_left", q.size(), 1);
        cycle();
        chk("full_done_valid", int'(out_valid), 0);
        chk("full_q_empty", q.size(), 0);

        // Backpressure
        out_ready = 1'b0;
        load(8'b1000_0101);
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_idx", int'(out_idx), 0);
            chk("stall_cnt", int'(pend_cnt), 3);
            cycle();
        end
        push(0, 3);
        push(2, 2);
        push(7, 1);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        cycle();
        chk("stall2_idx", int'(out_idx), 2);
        chk("stall2_cnt", int'(pend_cnt), 2);
        out_ready = 1'b1;
        cycle(2);
        chk("bp_done_valid", int'(out_valid), 0);
        chk("bp_q_empty", q.size(), 0);

        // Zero vector is dropped
        load(8'h00);
        chk("zero_valid", int'(out_valid), 0);
        chk("zero_ready", int'(in_ready), 1);
        cycle();
        chk("zero_valid2", int'(out_valid), 0);

        // Input during SERVE is ignored
        out_ready = 1'b0;
        push(0, 2);
        push(7, 1);
        load(8'h81);
        in_valid = 1'b1;
        in_bits  = 8'h01;
        cycle(2);
        in_valid = 1'b0;
        in_bits  = '0;
        out_ready = 1'b1;
        cycle(4);
        chk("ign_valid", int'(out_valid), 0);
        chk("ign_q_empty", q.size(), 0);

        // Reset mid-SERVE discards pending bits
        push(4, 4);
        load(8'hF0);
        cycle();
        out_ready = 1'b0;
        chk("pre_rst_idx", int'(out_idx), 5);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_ready", int'(in_ready), 1);
        chk("mid_rst_cnt", int'(pend_cnt), 0);
        cycle();
        rst = 1'b0;
        out_ready = 1'b1;
        cycle(3);
        chk("post_rst_valid", int'(out_valid), 0);
        push(1, 1);
        load(8'h02);
        cycle(2);
        chk("post_rst_done", int'(out_valid), 0);
        chk("final_q_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/onehot_serial_encoder.md
Name: onehot_serial_encoder

Overview:
- Inverse of the 3-to-8 decoder: takes an 8-bit request vector and emits the 3-bit index of each set bit, one index per handshake, lowest index first.
- Sits between request-collecting logic and any consumer of binary indices.
- Fully registered: no combinational path from input ports to output ports.
- Uses valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, request vector width; must be a power of two, range 2..64.
- IDX_W, $clog2(WIDTH), index width; derived, never overridden.

Ports:
- clk  input  1  system clock; rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  in_bits holds a vector to load.
- in_ready  output  1  block can accept a vector; high only in IDLE.
- in_bits  input  WIDTH  request vector; bit i set requests index i.
- out_valid  output  1  out_idx holds a valid index.
- out_ready  input  1  consumer accepts out_idx this cycle.
- out_idx  output  IDX_W  binary index of the lowest remaining set bit.
- pend_cnt  output  IDX_W+1  number of set bits remaining in pending, including the one on out_idx.

Behaviour:
- Reset value of all state and outputs: state=IDLE, pending=0, out_valid=0, out_idx=0, pend_cnt=0, in_ready=1.
- Reset mid-operation: pending vector is discarded immediately. No index is emitted after rst deasserts until a new vector is loaded.
- State encoding is two states, IDLE and SERVE. in_ready = (state==IDLE), decoded from the state register only.
- IDLE, in_valid=1 and in_bits!=0: pending<=in_bits, state<=SERVE.
  - Next cycle: out_valid=1, out_idx=lowest set bit, pend_cnt=popcount(in_bits).
  - Load-to-output latency is exactly 1 cycle.
- IDLE, in_valid=1 and in_bits==0: vector accepted and dropped; state stays IDLE; no output.
- IDLE, in_valid=0: hold.
- SERVE, out_valid & out_ready: clear bit out_idx in pending; pend_cnt decrements.
  - Remaining vector nonzero: next cycle out_idx = next lowest set bit; out_valid stays 1.
  - Remaining vector zero: state<=IDLE, out_valid<=0, pend_cnt<=0; out_idx holds its last value.
- SERVE, out_ready=0: out_valid, out_idx and pend_cnt held stable (no retraction, no change).
- Throughput: with out_ready held high, a vector with n set bits produces n indices on n consecutive cycles.
  - in_ready rises the cycle after the final handshake.
  - Back-to-back vectors therefore cost n+1 cycles each.
- in_valid during SERVE is ignored (in_ready=0); in_bits is not sampled.
- Index selection is lowest-set-bit priority; all-ones WIDTH=8 yields 0,1,...,7 in order.
- Next index and popcount are computed from the next-pending value and registered, so out_idx is a flop output.

Optional Feature:
- Macro: ONEHOT_ENC_LAST_EN.
- Defined:
  - Adds output port out_last (1 bit), asserted with out_valid when pend_cnt==1, i.e. on the final index of the current vector.
  - Reset value 0; held stable under stall like out_idx.
- Undefined: port absent; all other behaviour identical.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> in_ready=1, out_valid=0, out_idx=0, pend_cnt=0 immediately, without waiting for a clock edge.
- Single bit: load 8'b0010_0000, out_ready=1 -> next cycle out_idx=5, pend_cnt=1, out_valid=1; following cycle out_valid=0; in_ready=1 one cycle after the handshake.
- Full vector: load 8'hFF, out_ready=1 -> out_idx 0..7 on 8 consecutive cycles, pend_cnt 8 down to 1; with ONEHOT_ENC_LAST_EN, out_last=1 only with idx 7.
- Backpressure: load 8'b1000_0101, hold out_ready=0 for 3 cycles -> out_idx=0, pend_cnt=3 stable. Then toggle out_ready 1,0,1,1 -> indices 0, 2, 7 emitted on the three handshakes only.
- Zero vector and ignored input: load 8'h00 -> no out_valid, in_ready stays 1. Load 8'h81, then drive in_valid=1, in_bits=8'h01 during SERVE -> only indices 0, 7 emitted.
- Reset mid-SERVE: load 8'hF0, accept one index, then pulse rst -> out_valid=0 immediately; after release, load 8'h02 -> only index 1 emitted.
